// File: rtl/bus_interconnect_if.sv
// Master-side and slave-side serial bus bundle for bus_interconnect.
// The ic modport is the interconnect's own view of both sides.
interface bus_interconnect_if #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned NUM_S = 3
);
    logic [NUM_M-1:0] m_req;
    logic [NUM_M-1:0] m_grant;
    logic [NUM_M-1:0] m_valid;
    logic [NUM_M-1:0] m_tx_address;
    logic [NUM_M-1:0] m_tx_data;
    logic [NUM_M-1:0] m_write_en;
    logic [NUM_M-1:0] m_read_en;
    logic [NUM_M-1:0] m_rx_data;
    logic [NUM_M-1:0] m_slave_ready;

    logic [NUM_S-1:0] s_valid;
    logic [NUM_S-1:0] s_rx_address;
    logic [NUM_S-1:0] s_rx_data;
    logic [NUM_S-1:0] s_write_en;
    logic [NUM_S-1:0] s_read_en;
    logic [NUM_S-1:0] s_tx_data;
    logic [NUM_S-1:0] s_slave_ready;

    modport master (
        output m_req, m_valid, m_tx_address, m_tx_data, m_write_en, m_read_en,
        input  m_grant, m_rx_data, m_slave_ready
    );

    modport slave (
        input  s_valid, s_rx_address, s_rx_data, s_write_en, s_read_en,
        output s_tx_data, s_slave_ready
    );

    modport ic (
        input  m_req, m_valid, m_tx_address, m_tx_data, m_write_en, m_read_en,
        input  s_tx_data, s_slave_ready,
        output m_grant, m_rx_data, m_slave_ready,
        output s_valid, s_rx_address, s_rx_data, s_write_en, s_read_en
    );
endinterface

// File: rtl/bus_interconnect.sv
// Round-robin arbitrated serial-bus interconnect, NUM_M masters to NUM_S slaves.
// Optional watchdog abort is compiled in with `define BUS_TIMEOUT_EN.
module bus_interconnect #(
    parameter int unsigned NUM_M   = 2,
    parameter int unsigned NUM_S   = 3,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    bus_interconnect_if.ic bus,
    output logic           bus_busy,
    output logic           sel_err,
    output logic           timeout
);
    localparam int unsigned GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int unsigned BW = $clog2(SEL_W + 1);

    if (NUM_M < 2 || NUM_S < 1 || SEL_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("bus_interconnect: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, ADDR, CONNECT} state_t;

    state_t           r_state, w_state_n;
    logic [NUM_M-1:0] r_grant;
    logic [GW-1:0]    r_gidx, r_rr_ptr, w_win_idx, w_scan_idx;
    logic [SEL_W-1:0] r_sel, w_sel_next;
    logic [BW-1:0]    r_bit_cnt;
    logic [SW-1:0]    w_sidx;
    logic             r_busy, r_sel_err, r_timeout;
    logic             w_sel_err_n, w_timeout_n, w_wd_expire;
    logic             w_g_req, w_g_valid, w_g_addr, w_last_bit, w_sel_bad, w_start;
    logic [NUM_M-1:0] w_req_elig;

    assign w_g_req    = bus.m_req[r_gidx];
    assign w_g_valid  = bus.m_valid[r_gidx];
    assign w_g_addr   = bus.m_tx_address[r_gidx];
    assign w_sel_next = SEL_W'({r_sel, w_g_addr});
    assign w_last_bit = (r_bit_cnt == BW'(SEL_W - 1));
    assign w_sel_bad  = (w_sel_next == '0) || (32'(w_sel_next) > NUM_S);
    assign w_sidx     = SW'(r_sel - SEL_W'(1));
    assign w_start    = (r_state == IDLE) && (w_state_n == ADDR);

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]    r_wd_cnt;
    logic [NUM_M-1:0] r_blocked;
    logic             w_wd_clr;

    assign w_wd_clr    = (r_state == CONNECT) && bus.s_slave_ready[w_sidx];
    assign w_wd_expire = !w_wd_clr && (r_wd_cnt == TW'(TIMEOUT - 1));
    // A master aborted by the watchdog must drop its request before it can win again.
    assign w_req_elig  = bus.m_req & ~r_blocked;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_blocked <= '0;
        end else begin
            if (w_start || w_wd_clr)  r_wd_cnt <= '0;
            else if (r_state != IDLE) r_wd_cnt <= r_wd_cnt + TW'(1);
            r_blocked <= (r_blocked & bus.m_req) |
                         (w_timeout_n ? (NUM_M'(1) << r_gidx) : '0);
        end
    end
`else
    assign w_wd_expire = 1'b0;
    assign w_req_elig  = bus.m_req;
`endif

    // Round-robin search from rr_ptr+1 upward; the nearest requester is written last.
    always_comb begin
        w_win_idx  = '0;
        w_scan_idx = '0;
        for (int i = int'(NUM_M); i >= 1; i--) begin
            w_scan_idx = GW'((int'(r_rr_ptr) + i) % int'(NUM_M));
            if (w_req_elig[w_scan_idx]) w_win_idx = w_scan_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    // Release beats watchdog abort, which beats completion of the slave ID.
    always_comb begin
        w_state_n   = r_state;
        w_sel_err_n = 1'b0;
        w_timeout_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req_elig) w_state_n = ADDR;
            end
            ADDR: begin
                if (!w_g_req) begin
                    w_state_n = IDLE;
                end else if (w_wd_expire) begin
                    w_state_n   = IDLE;
                    w_timeout_n = 1'b1;
                end else if (w_g_valid && w_last_bit) begin
                    if (w_sel_bad) begin
                        w_state_n   = IDLE;
                        w_sel_err_n = 1'b1;
                    end else begin
                        w_state_n = CONNECT;
                    end
                end
            end
            CONNECT: begin
                if (!w_g_req) begin
                    w_state_n = IDLE;
                end else if (w_wd_expire) begin
                    w_state_n   = IDLE;
                    w_timeout_n = 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= GW'(NUM_M - 1);
            r_sel     <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_sel_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_busy    <= (w_state_n != IDLE);
            r_sel_err <= w_sel_err_n;
            r_timeout <= w_timeout_n;
            if (w_start) begin
                r_grant   <= NUM_M'(1) << w_win_idx;
                r_gidx    <= w_win_idx;
                r_rr_ptr  <= w_win_idx;
                r_sel     <= '0;
                r_bit_cnt <= '0;
            end else if (w_state_n == IDLE) begin
                r_grant <= '0;
            end else if (r_state == ADDR && w_g_valid) begin
                r_sel     <= w_sel_next;
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
        end
    end

    // Combinational routing, active only while connected.
    always_comb begin
        bus.s_valid       = '0;
        bus.s_rx_address  = '0;
        bus.s_rx_data     = '0;
        bus.s_write_en    = '0;
        bus.s_read_en     = '0;
        bus.m_rx_data     = '0;
        bus.m_slave_ready = '0;
        if (r_state == CONNECT) begin
            bus.s_valid[w_sidx]       = bus.m_valid[r_gidx];
            bus.s_rx_address[w_sidx]  = bus.m_tx_address[r_gidx];
            bus.s_rx_data[w_sidx]     = bus.m_tx_data[r_gidx];
            bus.s_write_en[w_sidx]    = bus.m_write_en[r_gidx];
            bus.s_read_en[w_sidx]     = bus.m_read_en[r_gidx];
            bus.m_rx_data[r_gidx]     = bus.s_tx_data[w_sidx];
            bus.m_slave_ready[r_gidx] = bus.s_slave_ready[w_sidx];
        end
    end

    assign bus.m_grant = r_grant;
    assign bus_busy    = r_busy;
    assign sel_err     = r_sel_err;
    assign timeout     = r_timeout;
endmodule
